// File: rtl/vcu_timer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vcu_timer_pkg
//  Description : Shared types and control-word field positions for the
//                vcu_timer_bank multi-channel countdown timer.
//  Revision    : 1.0 - initial release
// ============================================================================
package vcu_timer_pkg;

  // Command field of the control word
  typedef enum logic [1:0] {
    CMD_SEL   = 2'b00,
    CMD_START = 2'b01,
    CMD_STOP  = 2'b10,
    CMD_CLR   = 2'b11
  } cmd_e;

  // Per-channel countdown state
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } ch_state_e;

  // Control word field positions
  localparam int SEL_LSB   = 0;
  localparam int SEL_W     = 3;
  localparam int CMD_LSB   = 8;
  localparam int MODE_BIT  = 10;
  localparam int RDSEL_BIT = 11;

endpackage
`default_nettype wire

// File: rtl/vcu_timer_ch.sv
`default_nettype none
// ============================================================================
//  Module      : vcu_timer_ch
//  Description : One countdown channel: reload register, counter, IDLE/RUN/
//                DONE state machine, sticky expiry flag and registered tick.
//  Revision    : 1.0 - initial release
// ============================================================================
module vcu_timer_ch #(
  parameter int              CNT_W      = 28,
  parameter logic [CNT_W-1:0] RESET_LOAD = '0,
  parameter bit              BOOT       = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             clr,
  input  logic             mode_in,
  input  logic             load_we,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] count,
  output logic             expired,
  output logic             running,
  output logic             tick
);
  import vcu_timer_pkg::*;

  ch_state_e        state;
  logic [CNT_W-1:0] reload;
  logic             mode;       // 1 = periodic, 0 = one-shot
  logic             boot_pend;  // self-start on the first edge after reset
  logic             expire;

  assign expire  = (state == RUN) && (count == '0);
  assign running = (state == RUN);

  // Channel state machine: a restart (load or start) always owns the counter,
  // while the expiry of the current cycle still raises its tick and flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      count     <= '0;
      reload    <= RESET_LOAD;
      mode      <= 1'b0;
      expired   <= 1'b0;
      tick      <= 1'b0;
      boot_pend <= BOOT;
    end else begin
      tick      <= 1'b0;
      boot_pend <= 1'b0;

      if (load_we) begin
        reload <= load_val;
      end

      // Expiry beats a clear arriving in the same cycle
      if (expire) begin
        tick    <= 1'b1;
        expired <= 1'b1;
      end else if (clr) begin
        expired <= 1'b0;
      end

      if (start) begin
        mode <= mode_in;
      end

      if (load_we) begin
        count <= load_val;
        state <= RUN;
      end else if (start || boot_pend) begin
        count <= reload;
        state <= RUN;
      end else if (stop) begin
        state <= IDLE;
      end else begin
        case (state)
          RUN: begin
            if (count == '0) begin
              if (mode) begin
                count <= reload;
              end else begin
                state <= DONE;
              end
            end else begin
              count <= count - 1'b1;
            end
          end
          default: ;  // IDLE and DONE hold
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/vcu_timer_bank.sv
`default_nettype none
// ============================================================================
//  Module      : vcu_timer_bank
//  Description : NUM_CH countdown timers on the VCU register port. Decodes
//                the command word, keeps the channel/readback selection and
//                drives the zero-latency readback mux.
//  Revision    : 1.0 - initial release
// ============================================================================
module vcu_timer_bank #(
  parameter int          NUM_CH        = 4,
  parameter int          CNT_W         = 28,
  parameter logic [31:0] DEFAULT_LOAD  = 32'h2FAF080,
  parameter bit          IS_SIMULATION = 1'b0,
  parameter int          SIM_LOAD      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       vcu_reg_control,
  input  logic              vcu_reg_control_we,
  input  logic [31:0]       vcu_reg_wdata,
  input  logic              vcu_reg_wdata_we,
  output logic [31:0]       vcu_reg_rdata,
  output logic [NUM_CH-1:0] expired_p,
  output logic [NUM_CH-1:0] tick_p
);
  import vcu_timer_pkg::*;

  localparam logic [CNT_W-1:0] RESET_LOAD =
      IS_SIMULATION ? CNT_W'(SIM_LOAD) : CNT_W'(DEFAULT_LOAD);
  // Masking to clog2(NUM_CH) bits; a single channel yields a zero mask
  localparam int         SEL_BITS = $clog2(NUM_CH);
  localparam logic [2:0] SEL_MASK = 3'((1 << SEL_BITS) - 1);

  logic [2:0]  sel;
  logic        rd_sel;
  logic [2:0]  ctrl_sel;
  logic [2:0]  cur_sel;
  cmd_e        cmd;
  logic        cmd_mode;

  logic [NUM_CH-1:0] running;
  logic [CNT_W-1:0]  ch_count [NUM_CH];
  logic [31:0]       cnt_rd;
  logic [7:0]        exp_flags;
  logic [7:0]        run_flags;

  assign ctrl_sel = vcu_reg_control[SEL_LSB +: SEL_W] & SEL_MASK;
  assign cmd      = cmd_e'(vcu_reg_control[CMD_LSB +: 2]);
  assign cmd_mode = vcu_reg_control[MODE_BIT];
  // A wdata strobe in the same cycle as a control write uses the new sel
  assign cur_sel  = vcu_reg_control_we ? ctrl_sel : sel;

  // Channel and readback selection, updated on every control write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel    <= '0;
      rd_sel <= 1'b0;
    end else if (vcu_reg_control_we) begin
      sel    <= ctrl_sel;
      rd_sel <= vcu_reg_control[RDSEL_BIT];
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic hit;
    assign hit = (cur_sel == 3'(i));

    vcu_timer_ch #(
      .CNT_W      (CNT_W),
      .RESET_LOAD (RESET_LOAD),
      .BOOT       (i == 0)
    ) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (vcu_reg_control_we && hit && (cmd == CMD_START)),
      .stop     (vcu_reg_control_we && hit && (cmd == CMD_STOP)),
      .clr      (vcu_reg_control_we && hit && (cmd == CMD_CLR)),
      .mode_in  (cmd_mode),
      .load_we  (vcu_reg_wdata_we && hit),
      .load_val (vcu_reg_wdata[CNT_W-1:0]),
      .count    (ch_count[i]),
      .expired  (expired_p[i]),
      .running  (running[i]),
      .tick     (tick_p[i])
    );
  end

  // Count of the selected channel; unpopulated selections read zero
  always_comb begin
    cnt_rd = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (sel == 3'(i)) begin
        cnt_rd = 32'(ch_count[i]);
      end
    end
  end

  assign exp_flags     = 8'(expired_p);
  assign run_flags     = 8'(running);
  assign vcu_reg_rdata = rd_sel ? cnt_rd : {16'h0000, run_flags, exp_flags};

  logic unused_ctrl;
  assign unused_ctrl = ^{vcu_reg_control[31:12], vcu_reg_control[7:3]};

  if (CNT_W < 32) begin : g_wdata_trunc
    logic unused_wdata;
    assign unused_wdata = ^vcu_reg_wdata[31:CNT_W];
  end

endmodule
`default_nettype wire

// File: tb/tb_vcu_timer_bank.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vcu_timer_bank
//  Description : Self-checking bench for vcu_timer_bank. Expected tick events
//                are queued as stimulus is driven and matched against tick_p;
//                register readback is compared against hand-derived values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vcu_timer_bank;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 28;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [31:0]       vcu_reg_control = '0;
  logic              vcu_reg_control_we = 1'b0;
  logic [31:0]       vcu_reg_wdata = '0;
  logic              vcu_reg_wdata_we = 1'b0;
  logic [31:0]       vcu_reg_rdata;
  logic [NUM_CH-1:0] expired_p;
  logic [NUM_CH-1:0] tick_p;

  vcu_timer_bank #(
    .NUM_CH        (NUM_CH),
    .CNT_W         (CNT_W),
    .IS_SIMULATION (1'b1),
    .SIM_LOAD      (16)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .vcu_reg_control    (vcu_reg_control),
    .vcu_reg_control_we (vcu_reg_control_we),
    .vcu_reg_wdata      (vcu_reg_wdata),
    .vcu_reg_wdata_we   (vcu_reg_wdata_we),
    .vcu_reg_rdata      (vcu_reg_rdata),
    .expired_p          (expired_p),
    .tick_p             (tick_p)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    int         cyc;
    logic [3:0] mask;
  } tick_t;
  tick_t sb[$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push_tick(input int c, input logic [3:0] m);
    tick_t t;
    t.cyc  = c;
    t.mask = m;
    sb.push_back(t);
  endtask

  function automatic logic [31:0] cw(input logic [2:0] s, input logic [1:0] c,
                                     input bit m, input bit r);
    logic [31:0] w;
    w       = '0;
    w[2:0]  = s;
    w[9:8]  = c;
    w[10]   = m;
    w[11]   = r;
    return w;
  endfunction

  // One bus cycle; e is the clock edge at which the write takes effect
  task automatic bus(input bit c_we, input logic [31:0] c, input bit w_we,
                     input logic [31:0] w, output int e);
    @(negedge clk);
    vcu_reg_control    = c;
    vcu_reg_control_we = c_we;
    vcu_reg_wdata      = w;
    vcu_reg_wdata_we   = w_we;
    e = cyc + 1;
    @(negedge clk);
    vcu_reg_control_we = 1'b0;
    vcu_reg_wdata_we   = 1'b0;
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Tick monitor: every tick_p pulse must match the head of the scoreboard
  always @(negedge clk) begin
    if (rst_n) begin
      if (sb.size() > 0 && sb[0].cyc < cyc) begin
        check_val("tick_missed", 32'(cyc), 32'(sb[0].cyc));
        void'(sb.pop_front());
      end else if (sb.size() > 0 && sb[0].cyc == cyc) begin
        check_val("tick", 32'(tick_p), 32'(sb[0].mask));
        void'(sb.pop_front());
      end else if (tick_p != '0) begin
        check_val("tick_spurious", 32'(tick_p), 32'h0);
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int rel, e, e2, w;

    // ---------------- reset and power-on tick ----------------
    repeat (3) @(negedge clk);
    check_val("rst_expired", 32'(expired_p), 32'h0);
    check_val("rst_tick", 32'(tick_p), 32'h0);
    check_val("rst_rdata", vcu_reg_rdata, 32'h0);
    rst_n = 1'b1;
    rel = cyc;
    push_tick(rel + 18, 4'b0001);
    wait_cyc(rel + 5);
    check_val("boot_running", vcu_reg_rdata, 32'h0000_0100);
    wait_cyc(rel + 19);
    check_val("boot_expired", 32'(expired_p), 32'h1);
    check_val("boot_rdata", vcu_reg_rdata, 32'h0000_0001);
    bus(1'b1, cw(3'd0, 2'b11, 1'b0, 1'b0), 1'b0, 32'h0, e);
    check_val("clr_ch0", 32'(expired_p), 32'h0);

    // ---------------- ch2 periodic, reload 5 ----------------
    bus(1'b1, cw(3'd2, 2'b00, 1'b0, 1'b0), 1'b1, 32'd5, e);
    bus(1'b1, cw(3'd2, 2'b01, 1'b1, 1'b0), 1'b0, 32'h0, e2);
    for (int k = 1; k <= 4; k++) push_tick(e2 + 6 * k, 4'b0100);
    wait_cyc(e2 + 7);
    check_val("ch2_run_rdata", vcu_reg_rdata, 32'h0000_0404);
    wait_cyc(e2 + 25);
    bus(1'b1, cw(3'd2, 2'b10, 1'b0, 1'b0), 1'b0, 32'h0, e);
    bus(1'b1, cw(3'd2, 2'b11, 1'b0, 1'b0), 1'b0, 32'h0, e);
    check_val("ch2_stop_rdata", vcu_reg_rdata, 32'h0);

    // ---------------- ch1 one-shot, clear on expiry ----------------
    bus(1'b1, cw(3'd1, 2'b00, 1'b0, 1'b0), 1'b1, 32'd3, e);
    push_tick(e + 4, 4'b0010);
    wait_cyc(e + 2);
    bus(1'b1, cw(3'd1, 2'b11, 1'b0, 1'b0), 1'b0, 32'h0, w);
    check_val("clr_vs_expiry", 32'(expired_p), 32'h2);
    check_val("ch1_done_rdata", vcu_reg_rdata, 32'h0000_0002);
    bus(1'b1, cw(3'd1, 2'b11, 1'b0, 1'b1), 1'b0, 32'h0, w);
    check_val("ch1_cleared", 32'(expired_p), 32'h0);
    check_val("ch1_count", vcu_reg_rdata, 32'h0);

    // ---------------- ch3 stop/hold, then wdata restart ----------------
    bus(1'b1, cw(3'd3, 2'b00, 1'b0, 1'b1), 1'b1, 32'd30, e);
    wait_cyc(e + 5);
    check_val("ch3_count25", vcu_reg_rdata, 32'd25);
    wait_cyc(e + 19);
    bus(1'b1, cw(3'd3, 2'b10, 1'b0, 1'b1), 1'b0, 32'h0, w);
    check_val("ch3_stop10", vcu_reg_rdata, 32'd10);
    repeat (20) @(negedge clk);
    check_val("ch3_hold10", vcu_reg_rdata, 32'd10);
    bus(1'b0, 32'h0, 1'b1, 32'd7, w);
    check_val("ch3_reload7", vcu_reg_rdata, 32'd7);
    push_tick(w + 8, 4'b1000);
    wait_cyc(w + 9);
    check_val("ch3_expired", 32'(expired_p), 32'h8);

    // ---------------- async reset mid-count ----------------
    bus(1'b1, cw(3'd1, 2'b00, 1'b0, 1'b0), 1'b1, 32'd50, e);
    bus(1'b1, cw(3'd2, 2'b00, 1'b0, 1'b0), 1'b1, 32'd60, e);
    check_val("pre_rst_rdata", vcu_reg_rdata, 32'h0000_0608);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("mid_rst_expired", 32'(expired_p), 32'h0);
    check_val("mid_rst_tick", 32'(tick_p), 32'h0);
    check_val("mid_rst_rdata", vcu_reg_rdata, 32'h0);
    sb.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    rel = cyc;
    push_tick(rel + 18, 4'b0001);
    wait_cyc(rel + 3);
    check_val("rerun_only_ch0", vcu_reg_rdata, 32'h0000_0100);
    wait_cyc(rel + 19);
    check_val("rerun_expired", 32'(expired_p), 32'h1);
    check_val("rerun_rdata", vcu_reg_rdata, 32'h0000_0001);
    check_val("sb_drained", 32'(sb.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vcu_timer_bank.md
Name: vcu_timer_bank

Overview:
- Multi-channel countdown timer peripheral on the sr_cpu_vc video-control-unit register port (vcu_reg_control / vcu_reg_wdata / vcu_reg_rdata).
- Generalises the single free-running tick counter into NUM_CH independent channels, each with its own reload value and one-shot or periodic mode.
- Sticky expiry flags, a readable live count and per-expiry pulses for LEDs or display logic.
- Sits beside the CPU in the board top; rdata feeds the CPU read port directly.

Parameters:
- NUM_CH, 4, number of timer channels; legal range 1..8.
- CNT_W, 28, counter width in bits; legal range 8..32.
- DEFAULT_LOAD, 28'h2FAF080, reset reload value (hardware build).
- IS_SIMULATION, 0, 1 selects SIM_LOAD as the reset reload value.
- SIM_LOAD, 16, reset reload value for simulation builds.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- vcu_reg_control  in  32  command word.
- vcu_reg_control_we  in  1  command strobe, one cycle.
- vcu_reg_wdata  in  32  reload value for the selected channel.
- vcu_reg_wdata_we  in  1  reload strobe, one cycle.
- vcu_reg_rdata  out  32  status or count readback.
- expired_p  out  NUM_CH  sticky expiry flags.
- tick_p  out  NUM_CH  one-cycle pulse on each expiry event.

Behaviour:
- Reset, asynchronous on rst_n low:
  - All channels IDLE, count=0, expired=0, mode=one-shot.
  - Reload registers = IS_SIMULATION ? SIM_LOAD : DEFAULT_LOAD.
  - sel=0, rd_sel=0.
  - Channel 0 is then started in one-shot mode on the first clk edge after rst_n rises (count=reload). This preserves the power-on tick behaviour.
  - All outputs are 0 while rst_n is low. Reset asserted mid-count aborts every channel immediately.
- Control word fields:
  - [2:0] sel; bits at or above NUM_CH are ignored by masking to $clog2(NUM_CH) bits, and NUM_CH=1 forces sel to 0.
  - [9:8] cmd: 00 select-only, 01 start, 10 stop, 11 clear flag.
  - [10] mode: 1 periodic, 0 one-shot; latched for the selected channel on start.
  - [11] rd_sel: latched on every control write.
  - All other bits are ignored.
- Start: count <= reload, state RUN, effective on the next cycle.
- Stop: state IDLE, count held.
- Clear: expired[sel] <= 0.
- vcu_reg_wdata_we:
  - reload[sel] <= wdata[CNT_W-1:0]; upper bits are truncated.
  - Also restarts that channel: count <= new value, state RUN, mode unchanged.
- Channel FSM:
  - IDLE: hold.
  - RUN with count>0: count-1 per cycle.
  - RUN with count==0: tick_p=1 for that cycle and expired set. Periodic mode: count <= reload, stay RUN. One-shot mode: go to DONE.
  - DONE: hold count=0 until start or wdata write.
  - Period in periodic mode is reload+1 cycles. A reload of 0 expires every cycle in periodic mode.
- Simultaneous events:
  - Control and wdata strobes in the same cycle: the sel written this cycle is used by wdata. The wdata restart overrides a stop cmd.
  - Clear and expiry on the same channel in the same cycle: expiry wins, flag stays 1.
  - Start or wdata on the cycle the channel expires: the restart wins for count. The tick pulse and flag for the current expiry are still produced.
  - Events on different channels are independent.
- Readback, combinational from registers with zero latency:
  - rd_sel=0: rdata[7:0] = expired flags, rdata[15:8] = running (RUN) flags, rest 0. Flag bits at or above NUM_CH read 0.
  - rd_sel=1: rdata = count[sel], zero-extended.

Decomposition:
- Package vcu_timer_pkg:
  - cmd enum (CMD_SEL, CMD_START, CMD_STOP, CMD_CLR).
  - Channel state enum (IDLE, RUN, DONE).
  - Control-field bit position constants (SEL_LSB, CMD_LSB, MODE_BIT, RDSEL_BIT).
- Sub-module vcu_timer_ch: one channel with reload register, counter, FSM, flag and tick. Instantiated NUM_CH times via generate.
- Top-level logic: decode, select register and readback mux.

Test Plan:
- Reset release, IS_SIMULATION=1: ch0 counts from 16 → tick_p[0] pulses exactly 17 cycles after the first post-reset edge; expired_p=4'b0001; rdata (rd_sel=0) = 32'h0000_0001.
- wdata=5 to sel=2, then start periodic → tick_p[2] every 6 cycles for 4 periods; rdata = 32'h0000_0404 while running with the flag set.
- ch1 one-shot with reload 3, then clear cmd → DONE after 4 cycles; flag cleared; running bit 0; rd_sel=1 count reads 0.
- Clear cmd on ch1 in the same cycle as its expiry → expired_p[1] stays 1.
- Stop ch3 at count 10, read rd_sel=1 → 10 held for 20 cycles; a wdata write of 7 restarts it, and tick_p[3] fires 8 cycles later.
- Assert rst_n low mid-count on all channels → every output is 0 immediately, asynchronously; after release only ch0 runs.
